// File: rtl/edge_event_reporter_if.sv
// Event stream from the edge event reporter to its consumer (valid/ready handshake).
interface edge_event_reporter_if #(
    parameter int RW       = 3,
    parameter int TS_WIDTH = 8
);
    logic                event_valid;
    logic                event_ready;
    logic [RW-1:0]       event_row;
    logic [TS_WIDTH-1:0] event_time;
    logic                event_kind;

    modport master (
        output event_valid,
        output event_row,
        output event_time,
        output event_kind,
        input  event_ready
    );

    modport slave (
        input  event_valid,
        input  event_row,
        input  event_time,
        input  event_kind,
        output event_ready
    );
endinterface

// File: rtl/edge_event_reporter.sv
// Turns per-row detect onsets into timestamped events queued in a FIFO and drained over valid/ready.
// Define EDGE_REPORT_RELEASE_EN to also report falling edges (event_kind = 0).
module edge_event_reporter #(
    parameter int ROWS     = 5,
    parameter int DEPTH    = 8,
    parameter int TS_WIDTH = 8
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [ROWS-1:0]        det_in,
    edge_event_reporter_if.master  ev,
    output logic [7:0]             drop_count
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW = AW + 1;

    logic [ROWS-1:0]     det_q, det_d;
    logic [TS_WIDTH-1:0] ts_q, ts_d;
    logic [ROWS-1:0]     pend_on_q, pend_on_d;
    logic [TS_WIDTH-1:0] time_on_q [ROWS];
    logic [TS_WIDTH-1:0] time_on_d [ROWS];
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [RW-1:0]       mem_row_q  [DEPTH];
    logic [RW-1:0]       mem_row_d  [DEPTH];
    logic [TS_WIDTH-1:0] mem_time_q [DEPTH];
    logic [TS_WIDTH-1:0] mem_time_d [DEPTH];
    logic [7:0]          drop_count_q, drop_count_d;
`ifdef EDGE_REPORT_RELEASE_EN
    logic [ROWS-1:0]     pend_rel_q, pend_rel_d;
    logic [TS_WIDTH-1:0] time_rel_q [ROWS];
    logic [TS_WIDTH-1:0] time_rel_d [ROWS];
    logic                mem_kind_q [DEPTH];
    logic                mem_kind_d [DEPTH];
    logic [ROWS-1:0]     release_s, set_rel_s, lost_rel_s;
`endif

    logic [ROWS-1:0]     onset_s, set_on_s, lost_on_s;
    logic                sel_found_s, sel_kind_s;
    logic [RW-1:0]       sel_row_s;
    logic [TS_WIDTH-1:0] sel_time_s;
    logic                full_s, empty_s, pop_s, push_s;

    // Pick the lowest pending row; within a row an onset goes ahead of a release.
    always_comb begin
        sel_found_s = 1'b0;
        sel_kind_s  = 1'b1;
        sel_row_s   = {RW{1'b0}};
        sel_time_s  = {TS_WIDTH{1'b0}};
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (pend_on_q[i]) begin
                sel_found_s = 1'b1;
                sel_kind_s  = 1'b1;
                sel_row_s   = RW'(i);
                sel_time_s  = time_on_q[i];
`ifdef EDGE_REPORT_RELEASE_EN
            end else if (pend_rel_q[i]) begin
                sel_found_s = 1'b1;
                sel_kind_s  = 1'b0;
                sel_row_s   = RW'(i);
                sel_time_s  = time_rel_q[i];
`endif
            end else begin
                sel_found_s = sel_found_s;
            end
        end
    end

    // Next-state logic for edge capture, pending stage, FIFO and drop counter.
    always_comb begin
        onset_s   = det_in & ~det_q;
        set_on_s  = onset_s & ~pend_on_q;
        lost_on_s = onset_s & pend_on_q;
        full_s    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        empty_s   = (wr_ptr_q == rd_ptr_q);
        pop_s     = !empty_s && ev.event_ready;
        // A pop frees the slot the push needs, so a full FIFO can still accept.
        push_s    = sel_found_s && (!full_s || pop_s);
        det_d     = det_in;
        ts_d      = ts_q + TS_WIDTH'(1);
        wr_ptr_d  = push_s ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
        rd_ptr_d  = pop_s  ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
        drop_count_d = drop_count_q;
        for (int i = 0; i < ROWS; i++) begin
            pend_on_d[i] = set_on_s[i] |
                (pend_on_q[i] & ~(push_s && sel_kind_s && (sel_row_s == RW'(i))));
            time_on_d[i] = set_on_s[i] ? ts_q : time_on_q[i];
            drop_count_d = (lost_on_s[i] && (drop_count_d != 8'hFF)) ? (drop_count_d + 8'd1) : drop_count_d;
        end
`ifdef EDGE_REPORT_RELEASE_EN
        release_s  = ~det_in & det_q;
        set_rel_s  = release_s & ~pend_rel_q;
        lost_rel_s = release_s & pend_rel_q;
        for (int i = 0; i < ROWS; i++) begin
            pend_rel_d[i] = set_rel_s[i] |
                (pend_rel_q[i] & ~(push_s && !sel_kind_s && (sel_row_s == RW'(i))));
            time_rel_d[i] = set_rel_s[i] ? ts_q : time_rel_q[i];
            drop_count_d = (lost_rel_s[i] && (drop_count_d != 8'hFF)) ? (drop_count_d + 8'd1) : drop_count_d;
        end
`endif
        for (int j = 0; j < DEPTH; j++) begin
            mem_row_d[j]  = (push_s && (wr_ptr_q[AW-1:0] == AW'(j))) ? sel_row_s  : mem_row_q[j];
            mem_time_d[j] = (push_s && (wr_ptr_q[AW-1:0] == AW'(j))) ? sel_time_s : mem_time_q[j];
`ifdef EDGE_REPORT_RELEASE_EN
            mem_kind_d[j] = (push_s && (wr_ptr_q[AW-1:0] == AW'(j))) ? sel_kind_s : mem_kind_q[j];
`endif
        end
    end

    // State registers; reset also clears the FIFO storage so the head reads row 0, time 0, onset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            det_q        <= {ROWS{1'b0}};
            ts_q         <= {TS_WIDTH{1'b0}};
            pend_on_q    <= {ROWS{1'b0}};
            wr_ptr_q     <= {PW{1'b0}};
            rd_ptr_q     <= {PW{1'b0}};
            drop_count_q <= 8'd0;
            for (int i = 0; i < ROWS; i++) begin
                time_on_q[i] <= {TS_WIDTH{1'b0}};
            end
            for (int j = 0; j < DEPTH; j++) begin
                mem_row_q[j]  <= {RW{1'b0}};
                mem_time_q[j] <= {TS_WIDTH{1'b0}};
            end
`ifdef EDGE_REPORT_RELEASE_EN
            pend_rel_q <= {ROWS{1'b0}};
            for (int i = 0; i < ROWS; i++) begin
                time_rel_q[i] <= {TS_WIDTH{1'b0}};
            end
            for (int j = 0; j < DEPTH; j++) begin
                mem_kind_q[j] <= 1'b1;
            end
`endif
        end else begin
            det_q        <= det_d;
            ts_q         <= ts_d;
            pend_on_q    <= pend_on_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            drop_count_q <= drop_count_d;
            time_on_q    <= time_on_d;
            mem_row_q    <= mem_row_d;
            mem_time_q   <= mem_time_d;
`ifdef EDGE_REPORT_RELEASE_EN
            pend_rel_q   <= pend_rel_d;
            time_rel_q   <= time_rel_d;
            mem_kind_q   <= mem_kind_d;
`endif
        end
    end

    assign ev.event_valid = !empty_s;
    assign ev.event_row   = mem_row_q[rd_ptr_q[AW-1:0]];
    assign ev.event_time  = mem_time_q[rd_ptr_q[AW-1:0]];
`ifdef EDGE_REPORT_RELEASE_EN
    assign ev.event_kind  = mem_kind_q[rd_ptr_q[AW-1:0]];
`else
    assign ev.event_kind  = 1'b1;
`endif
    assign drop_count     = drop_count_q;
endmodule

// File: tb/tb_edge_event_reporter.sv
// Directed bench for edge_event_reporter: per-cycle vector table plus hand-written FIFO/reset/release sequences.
module tb_edge_event_reporter;
    logic       clk;
    logic       reset_n;
    logic [4:0] det_in;
    logic [7:0] drop_count;
    int         total;
    int         bad;
    int         cyc;
    logic [7:0] expq [$];

    edge_event_reporter_if #(.RW(3), .TS_WIDTH(8)) ev_if ();

    edge_event_reporter #(.ROWS(5), .DEPTH(8), .TS_WIDTH(8)) dut (
        .clock      (clk),
        .reset_n    (reset_n),
        .det_in     (det_in),
        .ev         (ev_if.master),
        .drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] det;
        logic       rdy;
        logic       valid;
        logic       chk_data;
        logic [2:0] row;
        logic [7:0] tm;
        logic       kind;
    } vec_t;

    vec_t tbl [17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk_head(input string name, input logic [2:0] row, input logic [7:0] tm, input logic kind);
        chk({name, "_valid"}, 32'(ev_if.event_valid), 32'd1);
        chk({name, "_row"},   32'(ev_if.event_row),   32'(row));
        chk({name, "_time"},  32'(ev_if.event_time),  32'(tm));
        chk({name, "_kind"},  32'(ev_if.event_kind),  32'(kind));
    endtask

    // One onset on row 3 (high two cycles, low two cycles); queue its timestamp if it should become an event.
    task automatic pulse_row3(input bit keep);
        if (keep) expq.push_back(cyc[7:0]);
        det_in = 5'b01000;
        step();
        step();
        det_in = 5'b00000;
        step();
        step();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        cyc = 0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        cyc   = 0;
        reset_n = 1'b0;
        det_in  = 5'b00000;
        ev_if.event_ready = 1'b0;

        //             det       rdy   valid chk   row   time   kind
        tbl[0]  = '{5'b00000, 1'b0, 1'b0, 1'b1, 3'd0, 8'd0,  1'b1};
        tbl[1]  = '{5'b00000, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0,  1'b1};
        tbl[2]  = '{5'b00000, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0,  1'b1};
        tbl[3]  = '{5'b00100, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0,  1'b1};
        tbl[4]  = '{5'b00100, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0,  1'b1};
        tbl[5]  = '{5'b00100, 1'b1, 1'b1, 1'b1, 3'd2, 8'd3,  1'b1};
        tbl[6]  = '{5'b00100, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0,  1'b1};
        tbl[7]  = '{5'b00000, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0,  1'b1};
        tbl[8]  = '{5'b00000, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0,  1'b1};
        tbl[9]  = '{5'b00000, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0,  1'b1};
        tbl[10] = '{5'b10011, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0,  1'b1};
        tbl[11] = '{5'b10011, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0,  1'b1};
        tbl[12] = '{5'b10011, 1'b1, 1'b1, 1'b1, 3'd0, 8'd10, 1'b1};
        tbl[13] = '{5'b10011, 1'b1, 1'b1, 1'b1, 3'd1, 8'd10, 1'b1};
        tbl[14] = '{5'b10011, 1'b1, 1'b1, 1'b1, 3'd4, 8'd10, 1'b1};
        tbl[15] = '{5'b10011, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0,  1'b1};
        tbl[16] = '{5'b00000, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0,  1'b1};

        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        cyc = 0;
        chk("reset_drop", 32'(drop_count), 32'd0);

`ifndef EDGE_REPORT_RELEASE_EN
        // Single onset latency and simultaneous onsets in ascending row order.
        for (int k = 0; k < 17; k++) begin
            det_in = tbl[k].det;
            ev_if.event_ready = tbl[k].rdy;
            chk("tbl_valid", 32'(ev_if.event_valid), 32'(tbl[k].valid));
            if (tbl[k].chk_data) begin
                chk("tbl_row",  32'(ev_if.event_row),  32'(tbl[k].row));
                chk("tbl_time", 32'(ev_if.event_time), 32'(tbl[k].tm));
                chk("tbl_kind", 32'(ev_if.event_kind), 32'(tbl[k].kind));
            end
            step();
        end

        // Fill the FIFO with 8 events, one more pending, two lost.
        ev_if.event_ready = 1'b0;
        for (int k = 0; k < 9; k++) pulse_row3(1'b1);
        pulse_row3(1'b0);
        pulse_row3(1'b0);
        chk("fill_drop", 32'(drop_count), 32'd2);
        chk_head("fill_head", 3'd3, expq[0], 1'b1);

        // Full FIFO: one cycle of simultaneous pop and write of the pending event.
        ev_if.event_ready = 1'b1;
        step();
        ev_if.event_ready = 1'b0;
        void'(expq.pop_front());
        chk_head("popw_head", 3'd3, expq[0], 1'b1);
        // Still full: next onset stays pending, the one after is lost.
        pulse_row3(1'b1);
        pulse_row3(1'b0);
        chk("popw_drop", 32'(drop_count), 32'd3);

        ev_if.event_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            chk_head("drain", 3'd3, expq[k], 1'b1);
            step();
        end
        chk("drain_empty", 32'(ev_if.event_valid), 32'd0);
        chk("drain_drop",  32'(drop_count), 32'd3);
`endif

        // Reset with events queued and a row held high through reset.
        ev_if.event_ready = 1'b0;
        for (int k = 0; k < 4; k++) pulse_row3(1'b0);
        chk("rst_pre_valid", 32'(ev_if.event_valid), 32'd1);
        det_in = 5'b00001;
        do_reset();
        chk("rst_valid", 32'(ev_if.event_valid), 32'd0);
        chk("rst_drop",  32'(drop_count), 32'd0);
        chk("rst_row",   32'(ev_if.event_row), 32'd0);
        chk("rst_time",  32'(ev_if.event_time), 32'd0);
        chk("rst_kind",  32'(ev_if.event_kind), 32'd1);
        step();
        chk("rst_c1_valid", 32'(ev_if.event_valid), 32'd0);
        step();
        chk_head("rst_onset", 3'd0, 8'd0, 1'b1);
        ev_if.event_ready = 1'b1;
        step();
        chk("rst_after_valid", 32'(ev_if.event_valid), 32'd0);
        step();
        chk("rst_after2_valid", 32'(ev_if.event_valid), 32'd0);

        // Row 1 pulse high for cycles 20..22.
        ev_if.event_ready = 1'b0;
        det_in = 5'b00000;
        do_reset();
        while (cyc < 20) step();
        det_in = 5'b00010;
        repeat (3) step();
        det_in = 5'b00000;
        while (cyc < 27) step();
        chk_head("pulse_onset", 3'd1, 8'd20, 1'b1);
        ev_if.event_ready = 1'b1;
        step();
`ifdef EDGE_REPORT_RELEASE_EN
        chk_head("pulse_release", 3'd1, 8'd23, 1'b0);
        step();
`endif
        chk("pulse_empty", 32'(ev_if.event_valid), 32'd0);
        step();
        chk("pulse_empty2", 32'(ev_if.event_valid), 32'd0);
        chk("pulse_drop",   32'(drop_count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/edge_event_reporter.md
# edge_event_reporter

Consumer of the edge detector's per-row result vector. Samples one detect flag per pixel row every clock, turns row onsets (0→1) into discrete timestamped events, buffers them in a FIFO and drains them over a valid/ready interface to a downstream logger or bus bridge. Sits directly after the detector stage of the pixel pipeline, in the same clock domain.

## Interface

- `ROWS`, 5, number of pixel rows (matches `PixelHeight`); row index width `RW = $clog2(ROWS)`, minimum 1
- `DEPTH`, 8, event FIFO depth; power of two, ≥ 2
- `TS_WIDTH`, 8, timestamp counter width

- `clock`  in  1  single clock, all logic on rising edge
- `reset_n`  in  1  synchronous, active-low reset
- `det_in`  in  ROWS  per-row detect flags, bit i = row i
- `event_valid`  out  1  FIFO head holds an event
- `event_ready`  in  1  downstream accepts head this cycle
- `event_row`  out  RW  row index of head event
- `event_time`  out  TS_WIDTH  timestamp of head event
- `event_kind`  out  1  1 = onset, 0 = release
- `drop_count`  out  8  saturating count of lost events

## Operation

- `det_q`: registered copy of `det_in`. `onset = det_in & ~det_q`; `release = ~det_in & det_q`.
- `ts`: free-running `TS_WIDTH` counter, +1 every cycle, wraps to 0.
- Pending stage: per-row `pend_on` bit plus per-row `time_on` register. On onset of row i with `pend_on[i]`=0: set `pend_on[i]`, `time_on[i]` ← current `ts`.
- Onset on a row already pending: event lost, original timestamp kept, `drop_count` +1 (saturates at 255).
- Enqueue: at most one event per cycle. Select lowest-index pending row. When FIFO not full, write {row, time, kind}; clear that row's pending bit. A pending bit set and cleared in the same cycle for the same row is impossible: the set requires the bit to be 0, and the clear requires it to be 1.
- FIFO full: pending bits hold; no loss until a row re-onsets.
- Dequeue: head pops when `event_valid && event_ready`. Write and pop in the same cycle are allowed at any occupancy, including full, where occupancy then stays unchanged.
- Outputs come straight from the FIFO head register/array. They are stable while `event_valid` is high and `event_ready` is low.

## Timing

- Reset (`reset_n` low at a rising edge): `det_q`, `ts`, all pending bits, FIFO pointers, and `drop_count` → 0.
- Reset outputs: `event_valid`=0, `event_row`=0, `event_time`=0, `event_kind`=1, `drop_count`=0.
- Reset mid-operation discards all queued and pending events.
- Because `det_q`=0 after reset, a row already high in the first cycle after reset is an onset.
- Latency: onset on `det_in` in cycle N (ts = T)
  - end of N: pending set
  - end of N+1: enqueued, if FIFO not full and the row has priority
  - cycle N+2: `event_valid`=1, `event_time`=T
- Each additional simultaneous onset adds one cycle, in ascending row order.
- Sustained throughput: one event per cycle.
- `event_time` wraps modulo 2^TS_WIDTH; the consumer handles wrap.

## Configuration

- `EDGE_REPORT_RELEASE_EN` defined:
  - Adds per-row `pend_rel`/`time_rel`. Falling edges (`release`) generate events with `event_kind`=0, using the same drop rule.
  - Priority: lowest row first. Within a row, onset before release. If both are pending for a row, the onset enqueues first and the release follows next cycle.
- Not defined:
  - Release logic is absent and falling edges are ignored.
  - `event_kind` is tied to 1.

## Test plan

- Reset, then `det_in`=5'b00100 held from cycle 3 (ts=3) → `event_valid` rises at cycle 5 with row=2, time=3, kind=1; exactly one event, no further events while the bit stays high.
- `det_in` 0→5'b10011 in one cycle at ts=10, `event_ready`=1 → events row 0, 1, 4 on consecutive cycles, all with time=10.
- `event_ready`=0, 9 onsets on one row (toggle period 4) with DEPTH=8 → 8 events queued, 1 pending, further re-onsets increment `drop_count`. Raise `event_ready` → 9 events drained in order, `drop_count` unchanged after the drain.
- FIFO full, `event_ready`=1 and a pending row → write and pop in the same cycle, occupancy stays 8, no drop.
- `reset_n` low for one cycle with 4 events queued → `event_valid`=0 and `drop_count`=0 the next cycle. A row held high through reset yields one onset event afterwards.
- With `EDGE_REPORT_RELEASE_EN`, row 1 pulse high for cycles 20–22 → onset event (time 20, kind 1) then release event (time 23, kind 0).
